// File: rtl/ob_table_qty_acc.sv
// ob_table_qty_acc: multi-beat crossing-quantity accumulator over an order-book table.
// Optional early exit once the requested quantity is covered: OB_TABLE_QTY_ACC_EARLY_EXIT_EN.
module ob_table_qty_acc #(
    parameter int N       = 16,
    parameter int LANES   = 6,
    parameter int PRICE_W = 32,
    parameter int QTY_W   = 16,
    parameter int ACC_W   = QTY_W + $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [PRICE_W-1:0]     cmd_price,
    input  logic                   cmd_is_ask,
    input  logic [ACC_W-1:0]       cmd_quantity,
    input  logic [N-1:0]           tbl_vld,
    input  logic [N*PRICE_W-1:0]   tbl_price,
    input  logic [N*QTY_W-1:0]     tbl_quantity,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [ACC_W-1:0]       rsp_quantity,
    output logic                   rsp_full,
    output logic                   busy
);

    localparam int BEATS  = (N + LANES - 1) / LANES;
    localparam int SLOTS  = BEATS * LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]         r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [ACC_W-1:0]   r_acc;
    logic [PRICE_W-1:0] r_price;
    logic               r_is_ask;
    logic [ACC_W-1:0]   r_cmd_qty;

    logic [N-1:0]       w_hit;
    logic [N*ACC_W-1:0] w_hq;
    logic [SLOTS*ACC_W-1:0] w_hq_pad;
    logic [ACC_W-1:0]   w_beat_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_last;
    logic               w_exit;
    logic               w_rsp;

    // Per-entry crossing test; equal prices always cross.
    // Packed BCD orders like plain unsigned binary.
    for (genvar gi = 0; gi < N; gi++) begin : g_ent
        logic [PRICE_W-1:0] w_p;
        logic [QTY_W-1:0]   w_q;
        logic               w_cross;

        assign w_p = tbl_price[gi*PRICE_W +: PRICE_W];
        assign w_q = tbl_quantity[gi*QTY_W +: QTY_W];

        assign w_cross = r_is_ask ? (r_price >= w_p)
                                  : (r_price <= w_p);

        assign w_hit[gi] = tbl_vld[gi] & w_cross;

        assign w_hq[gi*ACC_W +: ACC_W] =
            w_hit[gi] ? ACC_W'(w_q) : '0;
    end

    // Pad the last beat so lanes past N read as zero.
    for (genvar gs = 0; gs < SLOTS; gs++) begin : g_pad
        if (gs < N) begin : g_real
            assign w_hq_pad[gs*ACC_W +: ACC_W] =
                w_hq[gs*ACC_W +: ACC_W];
        end else begin : g_zero
            assign w_hq_pad[gs*ACC_W +: ACC_W] = '0;
        end
    end

    // Sum the LANES slots selected by the current beat.
    always_comb begin
        w_beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_beat_sum = w_beat_sum +
                w_hq_pad[(int'(r_beat) * LANES + l) * ACC_W +: ACC_W];
        end
    end

    assign w_acc_nxt = r_acc + w_beat_sum;
    assign w_last    = (r_beat == LAST_BEAT);

`ifdef OB_TABLE_QTY_ACC_EARLY_EXIT_EN
    assign w_exit = w_last |
                    ((r_cmd_qty != '0) & (w_acc_nxt >= r_cmd_qty));
`else
    assign w_exit = w_last;
`endif

    // Control FSM: IDLE accepts, ACC scans beats, RSP holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_vld) begin
                        r_state <= S_ACC;
                        r_beat  <= '0;
                    end
                end
                S_ACC: begin
                    if (w_exit) begin
                        r_state <= S_RSP;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    // Datapath: latch the command on accept, accumulate during ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_price   <= '0;
            r_is_ask  <= 1'b0;
            r_cmd_qty <= '0;
        end else begin
            if (r_state == S_IDLE && cmd_vld) begin
                r_acc     <= '0;
                r_price   <= cmd_price;
                r_is_ask  <= cmd_is_ask;
                r_cmd_qty <= cmd_quantity;
            end else if (r_state == S_ACC) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign w_rsp = (r_state == S_RSP);

    assign cmd_rdy      = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_vld      = w_rsp;
    assign rsp_quantity = w_rsp ? r_acc : '0;
    assign rsp_full     = w_rsp & (r_acc >= r_cmd_qty);

endmodule

// File: tb/tb_ob_table_qty_acc.sv
// tb_ob_table_qty_acc: directed vectors against ob_table_qty_acc.
// Expected responses are queued at issue and checked by an independent monitor.
module tb_ob_table_qty_acc;

    localparam int N       = 16;
    localparam int LANES   = 6;
    localparam int PRICE_W = 32;
    localparam int QTY_W   = 16;
    localparam int ACC_W   = QTY_W + $clog2(N + 1);
    localparam int BEATS   = (N + LANES - 1) / LANES;

`ifdef OB_TABLE_QTY_ACC_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [PRICE_W-1:0]   cmd_price;
    logic                 cmd_is_ask;
    logic [ACC_W-1:0]     cmd_quantity;
    logic [N-1:0]         tbl_vld;
    logic [N*PRICE_W-1:0] tbl_price;
    logic [N*QTY_W-1:0]   tbl_quantity;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic [ACC_W-1:0]     rsp_quantity;
    logic                 rsp_full;
    logic                 busy;

    ob_table_qty_acc #(
        .N(N), .LANES(LANES), .PRICE_W(PRICE_W), .QTY_W(QTY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_price(cmd_price), .cmd_is_ask(cmd_is_ask),
        .cmd_quantity(cmd_quantity),
        .tbl_vld(tbl_vld), .tbl_price(tbl_price),
        .tbl_quantity(tbl_quantity),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_quantity(rsp_quantity), .rsp_full(rsp_full),
        .busy(busy)
    );

    typedef struct {
        logic [ACC_W-1:0] q;
        logic             full;
        int               lat;
        int               acc_cyc;
        int               id;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   in_rsp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [PRICE_W-1:0] to_bcd(input int v);
        logic [PRICE_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < PRICE_W / 4; k++) begin
            r = r | (PRICE_W'(x % 10) << (4 * k));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic set_tbl(input logic [N-1:0] vm, input logic [QTY_W-1:0] qv);
        tbl_vld = vm;
        for (int i = 0; i < N; i++) begin
            tbl_price[i*PRICE_W +: PRICE_W] = to_bcd(100 + i);
            tbl_quantity[i*QTY_W +: QTY_W]  = qv;
        end
    endtask

    // Called at posedge+#1; returns just after the accept edge.
    task automatic send(input logic [PRICE_W-1:0] p, input bit ask,
                        input logic [ACC_W-1:0] q, input logic [ACC_W-1:0] eq,
                        input bit ef, input int el, input int id);
        exp_t e;
        int t = 0;
        while (!cmd_rdy && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_rdy) timeout($sformatf("cmd_rdy_wait%0d", id));
        cmd_vld      = 1'b1;
        cmd_price    = p;
        cmd_is_ask   = ask;
        cmd_quantity = q;
        e.q = eq; e.full = ef; e.lat = el; e.acc_cyc = cyc + 1; e.id = id;
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || in_rsp || busy) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) timeout("idle_wait");
    endtask

    // Monitor: pops the scoreboard when a response appears.
    initial begin : mon
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 1'b0;
            end else if (rsp_vld) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_rsp: got rsp_quantity=%0h, want no response",
                                 rsp_quantity);
                    end else begin
                        cur = sb.pop_front();
                        in_rsp = 1'b1;
                        chk($sformatf("latency%0d", cur.id), cyc - cur.acc_cyc, cur.lat);
                    end
                end
                if (in_rsp) begin
                    chk($sformatf("qty%0d", cur.id), 32'(rsp_quantity), 32'(cur.q));
                    chk($sformatf("full%0d", cur.id), 32'(rsp_full), 32'(cur.full));
                    chk($sformatf("rdy_in_rsp%0d", cur.id), 32'(cmd_rdy), 0);
                    chk($sformatf("busy_in_rsp%0d", cur.id), 32'(busy), 1);
                    if (rsp_rdy) in_rsp = 1'b0;
                end
            end else begin
                if (in_rsp) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rsp_dropped%0d: got rsp_vld=0, want 1", cur.id);
                    in_rsp = 1'b0;
                end
                chk("idle_qty", 32'(rsp_quantity), 0);
                chk("idle_full", 32'(rsp_full), 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish by 200000");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        rst_n        = 1'b0;
        cmd_vld      = 1'b0;
        cmd_price    = '0;
        cmd_is_ask   = 1'b0;
        cmd_quantity = '0;
        rsp_rdy      = 1'b1;
        set_tbl('0, 16'd10);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_qty", 32'(rsp_quantity), 0);
        chk("rst_full", 32'(rsp_full), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(to_bcd(100), 1'b1, 21'd1, 21'd0, 1'b0, BEATS, 1);
        wait_idle();

        set_tbl('1, 16'd10);
        send(to_bcd(105), 1'b1, 21'd61, 21'd60, 1'b0, BEATS, 2);
        send(to_bcd(105), 1'b1, 21'd0, 21'd60, 1'b1, BEATS, 3);
        send(to_bcd(110), 1'b0, 21'd61, 21'd60, 1'b0, BEATS, 4);
        send(to_bcd(99), 1'b0, 21'd0, 21'd160, 1'b1, BEATS, 5);
        wait_idle();

        set_tbl('1, 16'hFFFF);
        send('1, 1'b1, 21'h1FFFFF, 21'hFFFF0, 1'b0, BEATS, 6);
        wait_idle();
        set_tbl(16'h5555, 16'hFFFF);
        send('1, 1'b1, 21'h7FFF8, 21'h7FFF8, 1'b1, BEATS, 7);
        wait_idle();

        set_tbl('1, 16'd10);
        rsp_rdy = 1'b0;
        send(to_bcd(112), 1'b0, 21'd41, 21'd40, 1'b0, BEATS, 8);
        cmd_vld      = 1'b1;
        cmd_price    = to_bcd(103);
        cmd_is_ask   = 1'b1;
        cmd_quantity = 21'd0;
        t = 0;
        while (!rsp_vld && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!rsp_vld) timeout("bp_rsp_wait");
        repeat (5) @(posedge clk);
        #1;
        chk("bp_busy", 32'(busy), 1);
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_retire_rdy", 32'(cmd_rdy), 1);
        chk("bp_retire_busy", 32'(busy), 0);
        begin
            exp_t e;
            e.q = 21'd40; e.full = 1'b1; e.lat = BEATS;
            e.acc_cyc = cyc + 1; e.id = 9;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        chk("bp_second_accept", 32'(busy), 1);
        wait_idle();

        cmd_vld      = 1'b1;
        cmd_price    = to_bcd(115);
        cmd_is_ask   = 1'b1;
        cmd_quantity = 21'd200;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_vld", 32'(rsp_vld), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 1);
        chk("mid_rst_qty", 32'(rsp_quantity), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(to_bcd(115), 1'b1, 21'd200, 21'd160, 1'b0, BEATS, 10);
        wait_idle();

        send(to_bcd(115), 1'b1, 21'd25, EE ? 21'd60 : 21'd160, 1'b1,
             EE ? 1 : BEATS, 11);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
